// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch, LSB loads and ROB stores onto the byte-serial
// RAM/IO bus, splitting each access into 1/2/4 byte beats and returning a done pulse.
module mem_ctrl #(
  parameter logic [1:0] RAM_IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rob_xbp,
  input  logic        in_fetcher_flag,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_flag,
  output logic [31:0] out_fetcher_data,
  input  logic        in_lsb_flag,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_addr,
  output logic        out_lsb_flag,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_flag,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_addr,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_flag,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  state_t r_state, w_state_nxt;

  logic        r_f_vld;
  logic [31:0] r_f_addr;
  logic        r_l_vld, r_l_sgn;
  logic [5:0]  r_l_size;
  logic [31:0] r_l_addr;
  logic        r_r_vld;
  logic [5:0]  r_r_size;
  logic [31:0] r_r_addr, r_r_data;
  logic [31:0] r_base, r_acc;
  logic [5:0]  r_k, r_len;
  logic        r_sgn, r_own_lsb;

  logic        w_f_pend, w_l_pend;
  logic        w_pick_rob, w_pick_lsb, w_pick_f;
  logic        w_rd_last, w_rd_done, w_wr_all, w_wr_done, w_io_stall;
  logic [1:0]  w_wr_k;
  logic [31:0] w_wr_addr, w_acc_nxt;
  logic [7:0]  w_wr_byte;

  function automatic logic [31:0] extend_rd(input logic [31:0] w, input logic [5:0] n,
                                            input logic s);
    case (n)
      6'd1:    return {{24{s & w[7]}}, w[7:0]};
      6'd2:    return {{16{s & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // A flush hides the fetch and LSB slots from arbitration in the same cycle.
  assign w_f_pend   = r_f_vld & ~in_rob_xbp;
  assign w_l_pend   = r_l_vld & ~in_rob_xbp;
  assign w_pick_rob = r_r_vld;
  assign w_pick_lsb = ~r_r_vld & w_l_pend;
  assign w_pick_f   = ~r_r_vld & ~w_l_pend & w_f_pend;

  assign w_rd_last  = (r_k + 6'd1) >= r_len;
  assign w_rd_done  = (r_state == S_READ) & ~in_rob_xbp & w_rd_last;
  assign w_wr_all   = (r_k == r_len);
  assign w_wr_done  = (r_state == S_WRITE) & w_wr_all;

  assign w_wr_k     = (r_state == S_WRITE) ? r_k[1:0] : 2'd0;
  assign w_wr_addr  = r_r_addr + {30'd0, w_wr_k};
  assign w_wr_byte  = r_r_data[{w_wr_k, 3'b000} +: 8];
  assign w_io_stall = (w_wr_addr[17:16] == RAM_IO_HI) & io_buffer_full;

  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[{r_k[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_rob)                  w_state_nxt = S_WRITE;
        else if (w_pick_lsb || w_pick_f) w_state_nxt = S_READ;
      end
      S_READ:  if (in_rob_xbp || w_rd_last) w_state_nxt = S_IDLE;
      S_WRITE: if (w_wr_all)                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      r_state <= S_IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_vld          <= 1'b0;
      r_l_vld          <= 1'b0;
      r_r_vld          <= 1'b0;
      r_k              <= 6'd0;
      out_fetcher_flag <= 1'b0;
      out_fetcher_data <= 32'd0;
      out_lsb_flag     <= 1'b0;
      out_lsb_data     <= 32'd0;
      out_rob_flag     <= 1'b0;
      mem_dout         <= 8'd0;
      mem_a            <= 32'd0;
      mem_wr           <= 1'b0;
    end else if (rdy) begin
      out_fetcher_flag <= 1'b0;
      out_lsb_flag     <= 1'b0;
      out_rob_flag     <= 1'b0;

      if (in_rob_xbp) r_f_vld <= 1'b0;
      else if (in_fetcher_flag && !r_f_vld) begin
        r_f_vld  <= 1'b1;
        r_f_addr <= in_fetcher_addr;
      end else if (w_rd_done && !r_own_lsb) r_f_vld <= 1'b0;

      if (in_rob_xbp) r_l_vld <= 1'b0;
      else if (in_lsb_flag && !r_l_vld) begin
        r_l_vld  <= 1'b1;
        r_l_size <= in_lsb_size;
        r_l_sgn  <= in_lsb_signed;
        r_l_addr <= in_lsb_addr;
      end else if (w_rd_done && r_own_lsb) r_l_vld <= 1'b0;

      if (in_rob_flag && !r_r_vld) begin
        r_r_vld  <= 1'b1;
        r_r_size <= in_rob_size;
        r_r_addr <= in_rob_addr;
        r_r_data <= in_rob_data;
      end else if (w_wr_done) r_r_vld <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_pick_rob) begin
            mem_a    <= w_wr_addr;
            mem_dout <= w_wr_byte;
            mem_wr   <= ~w_io_stall;
            r_k      <= w_io_stall ? 6'd0 : 6'd1;
            r_len    <= r_r_size;
          end else if (w_pick_lsb) begin
            mem_a     <= r_l_addr;
            r_base    <= r_l_addr;
            r_len     <= r_l_size;
            r_sgn     <= r_l_sgn;
            r_own_lsb <= 1'b1;
            r_k       <= 6'd0;
            r_acc     <= 32'd0;
            mem_wr    <= 1'b0;
          end else if (w_pick_f) begin
            mem_a     <= r_f_addr;
            r_base    <= r_f_addr;
            r_len     <= 6'd4;
            r_sgn     <= 1'b0;
            r_own_lsb <= 1'b0;
            r_k       <= 6'd0;
            r_acc     <= 32'd0;
            mem_wr    <= 1'b0;
          end
        end
        // Read beats: byte k arrives for the address presented last cycle.
        S_READ: begin
          mem_wr <= 1'b0;
          if (!in_rob_xbp) begin
            r_acc <= w_acc_nxt;
            if (w_rd_last) begin
              if (r_own_lsb) begin
                out_lsb_flag <= 1'b1;
                out_lsb_data <= extend_rd(w_acc_nxt, r_len, r_sgn);
              end else begin
                out_fetcher_flag <= 1'b1;
                out_fetcher_data <= w_acc_nxt;
              end
            end else begin
              mem_a <= r_base + {26'd0, r_k} + 32'd1;
              r_k   <= r_k + 6'd1;
            end
          end
        end
        // A stalled IO beat keeps r_k so the same byte is retried next edge.
        S_WRITE: begin
          if (w_wr_all) begin
            mem_wr       <= 1'b0;
            out_rob_flag <= 1'b1;
          end else begin
            mem_a    <= w_wr_addr;
            mem_dout <= w_wr_byte;
            mem_wr   <= ~w_io_stall;
            if (!w_io_stall) r_k <= r_k + 6'd1;
          end
        end
        default: mem_wr <= 1'b0;
      endcase
    end
  end

endmodule
